// File: rtl/act_mem_pkg.sv
// Shared definitions for the activation-memory read path.
// Holds the default address/data/length widths and the streamer FSM state type.
// No ports; imported by act_mem_read_streamer.
package act_mem_pkg;

   localparam int ACT_ADDR_W = 10;   // activation-memory word address width
   localparam int ACT_DATA_W = 32;   // 4 x 8-bit activations per word
   localparam int ACT_LEN_W  = 10;   // transfer length counter width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO used as the streamer output buffer (DEPTH a power of two, >= 2).
// Latency: a pushed word is visible on pop_data the cycle after the push edge; pop_data is 0 when empty.
// Backpressure: push is taken when not full, or when full with a simultaneous pop; flush empties at the edge.
// Ports: clk, reset (sync, active-high), flush, push/push_data, pop/pop_data, count, full, empty.
module stream_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   // At full, the slot under wr_ptr is the one being popped this cycle, so the write is safe.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; the empty gate on pop_data hides stale contents.
   always_ff @(posedge clk) begin
      if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/act_mem_read_streamer.sv
// Streams a strided run of words from activation memory into a small output buffer.
// Latency: first out_valid two edges after the start edge; one word per cycle sustained.
// Backpressure: reads are issued only while buffered + in-flight words leave room, so no word is dropped.
// Ports: clk/reset (sync, active-high); start/abort/base_addr/length/stride command;
//        mem_stall, rd_enable, rd_addr, rd_data memory port; out_valid/out_ready/out_data stream;
//        busy (not IDLE), done (one-cycle completion pulse).
module act_mem_read_streamer
   import act_mem_pkg::*;
#(
   parameter int ADDR_W     = ACT_ADDR_W,
   parameter int DATA_W     = ACT_DATA_W,
   parameter int LEN_W      = ACT_LEN_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [ADDR_W-1:0] stride,
   input  logic              mem_stall,
   output logic              rd_enable,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] stride_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issued_q;
   logic              inflight_q;

   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W:0]    occupancy;
   logic              credit_ok;
   logic              pop;

   // A word already requested but not yet landed still owns a buffer slot.
   assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
   assign credit_ok = occupancy < (CNT_W+1)'(FIFO_DEPTH);

   assign rd_enable = (state_q == RUN) && !mem_stall && (issued_q < len_q) && credit_ok;
   assign rd_addr   = addr_q;
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign busy      = (state_q != IDLE);

   stream_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (abort),
      .push      (inflight_q),
      .push_data (rd_data),
      .pop       (pop),
      .pop_data  (out_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            // A zero-length job skips RUN and completes straight out of DRAIN.
            if (start) state_d = (length == '0) ? DRAIN : RUN;
         end
         RUN: begin
            if (rd_enable && ((issued_q + LEN_W'(1)) == len_q)) state_d = DRAIN;
         end
         DRAIN: begin
            if (fifo_empty && !inflight_q) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort || reset) begin
         state_d = IDLE;
         done    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         stride_q   <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         // An abort discards the word currently returning from memory.
         inflight_q <= rd_enable && !abort;
         if ((state_q == IDLE) && start && !abort) begin
            addr_q   <= base_addr;
            stride_q <= stride;
            len_q    <= length;
            issued_q <= '0;
         end else if (rd_enable) begin
            addr_q   <= addr_q + stride_q;
            issued_q <= issued_q + LEN_W'(1);
         end
      end
   end

   // The credit rule must never let a landing word meet a full buffer without a pop.
   no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(inflight_q && fifo_full && !pop));

endmodule

// File: tb/tb_act_mem_read_streamer.sv
module tb_act_mem_read_streamer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset, start, abort, mem_stall, out_ready;
   logic [9:0]  base_addr, length, stride;
   logic        rd_enable, out_valid, busy, done;
   logic [9:0]  rd_addr;
   logic [31:0] rd_data, out_data;

   act_mem_read_streamer #(.ADDR_W(10), .DATA_W(32), .LEN_W(10), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .base_addr(base_addr), .length(length), .stride(stride),
      .mem_stall(mem_stall), .rd_enable(rd_enable), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents are a fixed function of the address, so any misrouted word shows up.
   function automatic logic [31:0] word_of(input logic [9:0] a);
      return {12'hA5C, a, ~a};
   endfunction

   // Activation memory: data appears one cycle after the read strobe.
   always @(posedge clk) rd_data <= rd_enable ? word_of(rd_addr) : 32'hDEADBEEF;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A job is a list of addresses base + k*stride. Words issued but not consumed may not exceed
   // the buffer depth; a word becomes visible two cycles after its read; done follows the last pop.
   bit   model_on = 0;
   bit   active = 0, rd_prev = 0, was_active;
   int   m_base, m_len, m_stride;
   int   n_iss, n_pop, n_arr, outst;
   bit   exp_rd, exp_vld, exp_done;

   // observations for the directed checks
   logic [9:0] obs_addr[$];
   int rd_cnt, pop_cnt, done_cnt, stall_rd, stall_cyc;
   int start_cyc, first_valid_cyc, last_pop_cyc, done_cyc;
   logic [31:0] first_data;

   function automatic logic [9:0] addr_k(input int k);
      return 10'(m_base + k * m_stride);
   endfunction

   always @(negedge clk) begin
      if (model_on) begin
         outst    = n_iss - n_pop;
         exp_rd   = active && (n_iss < m_len) && !mem_stall && (outst < DEPTH);
         exp_vld  = (n_arr - n_pop) > 0;
         exp_done = active && (n_iss == m_len) && (n_pop == m_len) && !abort && !reset;

         chk("rd_enable", 32'(rd_enable), 32'(exp_rd));
         if (exp_rd) chk("rd_addr", 32'(rd_addr), 32'(addr_k(n_iss)));
         chk("out_valid", 32'(out_valid), 32'(exp_vld));
         if (exp_vld) chk("out_data", out_data, word_of(addr_k(n_pop)));
         chk("busy", 32'(busy), 32'(active));
         chk("done", 32'(done), 32'(exp_done));

         if (rd_enable) begin obs_addr.push_back(rd_addr); rd_cnt++; end
         if (mem_stall && rd_enable) stall_rd++;
         if (mem_stall && busy) stall_cyc++;
         if (out_valid && first_valid_cyc < 0) begin first_valid_cyc = cyc; first_data = out_data; end
         if (out_valid && out_ready) begin pop_cnt++; last_pop_cyc = cyc; end
         if (done) begin done_cnt++; done_cyc = cyc; end

         if (reset || abort) begin
            active = 0; n_iss = 0; n_pop = 0; n_arr = 0; rd_prev = 0;
         end else begin
            was_active = active;
            if (exp_vld && out_ready) n_pop++;
            n_arr  += 32'(rd_prev);
            rd_prev = exp_rd;
            if (exp_rd) n_iss++;
            if (exp_done) active = 0;
            if (!was_active && start) begin
               active = 1; m_base = base_addr; m_len = length; m_stride = stride;
               n_iss = 0; n_pop = 0; n_arr = 0; rd_prev = 0; start_cyc = cyc;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic clear_obs();
      obs_addr.delete();
      rd_cnt = 0; pop_cnt = 0; done_cnt = 0; stall_rd = 0; stall_cyc = 0;
      first_valid_cyc = -1; last_pop_cyc = -1; done_cyc = -1; start_cyc = -1;
   endtask

   // Presents start for one cycle; returns #1 into the first cycle after the start edge.
   task automatic start_xfer(input logic [9:0] b, input logic [9:0] l, input logic [9:0] s);
      clear_obs();
      @(posedge clk); #1;
      start = 1; base_addr = b; length = l; stride = s;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic wait_done(input int max_cyc);
      int k = 0;
      while (done_cnt == 0 && k < max_cyc) begin
         @(negedge clk); #1;
         k++;
      end
      chk("done_seen_within_budget", 32'(done_cnt), 32'd1);
   endtask

   task automatic chk_addrs(input string name, input logic [9:0] exp[$]);
      chk({name, "_count"}, 32'(obs_addr.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < obs_addr.size(); i++)
         chk(name, 32'(obs_addr[i]), 32'(exp[i]));
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_rd_enable"}, 32'(rd_enable), 32'd0);
      chk({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_data"},  out_data,       32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_done"},      32'(done),      32'd0);
   endtask

   initial begin
      logic [9:0] exp_a[$];
      reset = 1; start = 0; abort = 0; mem_stall = 0; out_ready = 1;
      base_addr = '0; length = '0; stride = '0;
      clear_obs();
      repeat (2) @(posedge clk);
      #1;
      reset = 0; model_on = 1;
      chk_idle_zero("reset");

      // Basic 4-word run: addresses 0x010..0x013, full rate, done the cycle after the last pop.
      start_xfer(10'h010, 10'd4, 10'd1);
      wait_done(30);
      exp_a = '{10'h010, 10'h011, 10'h012, 10'h013};
      chk_addrs("basic_addr", exp_a);
      chk("basic_pops", 32'(pop_cnt), 32'd4);
      chk("basic_first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd3);
      chk("basic_first_data", first_data, 32'hA5C043EF);
      chk("basic_rate", 32'(last_pop_cyc - first_valid_cyc), 32'd3);
      chk("basic_done_after_pop", 32'(done_cyc - last_pop_cyc), 32'd1);
      chk("basic_total_lat", 32'(done_cyc - start_cyc), 32'd7);

      // Address wrap at the top of the 10-bit space.
      start_xfer(10'h3FE, 10'd4, 10'd1);
      wait_done(30);
      exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      chk_addrs("wrap_addr", exp_a);

      // Consumer blocked: only the buffer depth worth of reads may issue.
      out_ready = 0;
      start_xfer(10'h040, 10'd8, 10'd2);
      repeat (10) @(posedge clk);
      #1;
      chk("block_reads", 32'(rd_cnt), 32'd4);
      chk("block_valid", 32'(out_valid), 32'd1);
      out_ready = 1;
      wait_done(40);
      chk("block_pops", 32'(pop_cnt), 32'd8);
      exp_a = '{10'h040, 10'h042, 10'h044, 10'h046, 10'h048, 10'h04A, 10'h04C, 10'h04E};
      chk_addrs("block_addr", exp_a);

      // Memory stalled for three cycles after the first read.
      start_xfer(10'h100, 10'd8, 10'd3);
      @(posedge clk); #1;
      mem_stall = 1;
      repeat (3) @(posedge clk);
      #1;
      mem_stall = 0;
      wait_done(40);
      chk("stall_cycles", 32'(stall_cyc), 32'd3);
      chk("stall_no_read", 32'(stall_rd), 32'd0);
      chk("stall_total_lat", 32'(done_cyc - start_cyc), 32'd14);
      exp_a = '{10'h100, 10'h103, 10'h106, 10'h109, 10'h10C, 10'h10F, 10'h112, 10'h115};
      chk_addrs("stall_addr", exp_a);

      // Abort one cycle after the first read issues.
      start_xfer(10'h020, 10'd4, 10'd1);
      @(posedge clk); #1;
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      chk("abort_no_pop", 32'(pop_cnt), 32'd0);

      // Zero-length job: no reads, done in the cycle after start.
      start_xfer(10'h050, 10'd0, 10'd1);
      chk("zero_done_now", 32'(done), 32'd1);
      @(posedge clk); #1;
      chk("zero_busy_after", 32'(busy), 32'd0);
      chk("zero_reads", 32'(rd_cnt), 32'd0);
      chk("zero_done_lat", 32'(done_cyc - start_cyc), 32'd1);

      // A second start while busy is ignored.
      start_xfer(10'h060, 10'd6, 10'd1);
      @(posedge clk); #1;
      start = 1; base_addr = 10'h200; length = 10'd2;
      @(posedge clk); #1;
      start = 0;
      wait_done(40);
      chk("busy_start_pops", 32'(pop_cnt), 32'd6);
      exp_a = '{10'h060, 10'h061, 10'h062, 10'h063, 10'h064, 10'h065};
      chk_addrs("busy_start_addr", exp_a);

      // Abort wins over start in IDLE.
      clear_obs();
      @(posedge clk); #1;
      start = 1; abort = 1; base_addr = 10'h070; length = 10'd3; stride = 10'd1;
      @(posedge clk); #1;
      start = 0; abort = 0;
      chk("abort_prio_busy", 32'(busy), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("abort_prio_reads", 32'(rd_cnt), 32'd0);

      // Reset in the middle of a blocked transfer.
      out_ready = 0;
      start_xfer(10'h080, 10'd8, 10'd1);
      repeat (3) @(posedge clk);
      #1;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      chk_idle_zero("midreset");
      chk("midreset_no_done", 32'(done_cnt), 32'd0);
      out_ready = 1;

      // Recovery after reset.
      start_xfer(10'h0F0, 10'd2, 10'd5);
      wait_done(30);
      exp_a = '{10'h0F0, 10'h0F5};
      chk_addrs("recover_addr", exp_a);
      chk("recover_pops", 32'(pop_cnt), 32'd2);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "timeout");
   end

endmodule
